vec_reg_file_pipe: RTL

//  Parametrised vector register file for the RF stage: NumVecRegs registers, each Lanes x DataWidth.

---
 rtl/vec_reg_file_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vec_reg_file_pipe.sv
// ============================================================================
// Module   : vec_reg_file_pipe
// Brief    : Vector register file with swizzled, registered read ports,
//            a lane-masked write port and a hardware clear sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vec_reg_file_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int LANES          = 4,
    parameter int NUM_VEC_REGS   = 32,
    parameter int INDEX_WIDTH    = 5,
    parameter int NUM_READ_PORTS = 3,
    parameter int BYPASS_EN      = 1
) (
    input  logic                                            clk,
    input  logic                                            rstn,
    input  logic                                            i_clear_req,
    output logic                                            o_ready,
    input  logic                                            i_write_en,
    input  logic [INDEX_WIDTH-1:0]                          i_write_addr,
    input  logic [LANES*DATA_WIDTH-1:0]                     i_write_data,
    input  logic [LANES-1:0]                                i_write_mask,
    input  logic [NUM_READ_PORTS-1:0]                       i_read_en,
    input  logic [NUM_READ_PORTS*INDEX_WIDTH-1:0]           i_read_addr,
    input  logic [NUM_READ_PORTS*LANES*$clog2(LANES)-1:0]   i_read_swizzle,
    output logic [NUM_READ_PORTS*LANES*DATA_WIDTH-1:0]      o_read_data,
    output logic [NUM_READ_PORTS-1:0]                       o_read_valid
);

    localparam int C_LSW = $clog2(LANES);
    localparam int C_SW  = LANES * C_LSW;
    localparam int C_VW  = LANES * DATA_WIDTH;
    localparam int C_AW  = (NUM_VEC_REGS > 1) ? $clog2(NUM_VEC_REGS) : 1;
    localparam logic [INDEX_WIDTH:0]   C_NUM_REGS = (INDEX_WIDTH+1)'(NUM_VEC_REGS);
    localparam logic [INDEX_WIDTH-1:0] C_LAST_REG = INDEX_WIDTH'(NUM_VEC_REGS - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [INDEX_WIDTH-1:0]  r_clr_ptr;
    logic [INDEX_WIDTH-1:0]  w_clr_ptr_nxt;
    logic                    w_clr_wr;
    logic                    w_wr_acc;

    logic [DATA_WIDTH-1:0]   r_mem   [NUM_VEC_REGS][LANES];
    logic [DATA_WIDTH-1:0]   w_wlane [LANES];

    logic [INDEX_WIDTH-1:0]  w_raddr [NUM_READ_PORTS];
    logic                    w_rin   [NUM_READ_PORTS];
    logic                    w_hit   [NUM_READ_PORTS];
    logic [C_LSW-1:0]        w_src   [NUM_READ_PORTS][LANES];
    logic [DATA_WIDTH-1:0]   w_rlane [NUM_READ_PORTS][LANES];
    logic [DATA_WIDTH-1:0]   r_rlane [NUM_READ_PORTS][LANES];
    logic [NUM_READ_PORTS-1:0] r_rvalid;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_clr_wr      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_wr      = 1'b1;
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == C_LAST_REG) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_ptr_nxt = '0;
                end
            end
            S_IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    assign o_ready = (r_state == S_IDLE);

    // A clear request in the same cycle takes priority and drops the write.
    assign w_wr_acc = o_ready && i_write_en && !i_clear_req &&
                      (i_write_addr != '0) && ({1'b0, i_write_addr} < C_NUM_REGS);

    // ---------------- storage ----------------
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_wlane
            assign w_wlane[l] = i_write_data[l*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            for (int l = 0; l < LANES; l++) begin
                r_mem[C_AW'(r_clr_ptr)][l] <= '0;
            end
        end else if (w_wr_acc) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_write_mask[l]) begin
                    r_mem[C_AW'(i_write_addr)][l] <= w_wlane[l];
                end
            end
        end
    end

    // ---------------- read ports ----------------
    generate
        for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
            assign w_raddr[p] = i_read_addr[p*INDEX_WIDTH +: INDEX_WIDTH];
            assign w_rin[p]   = (w_raddr[p] != '0) && ({1'b0, w_raddr[p]} < C_NUM_REGS);
            assign w_hit[p]   = (BYPASS_EN != 0) && w_wr_acc && (i_write_addr == w_raddr[p]);
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                assign w_src[p][l] = i_read_swizzle[p*C_SW + l*C_LSW +: C_LSW];
                assign o_read_data[p*C_VW + l*DATA_WIDTH +: DATA_WIDTH] = r_rlane[p][l];
            end
        end
    endgenerate

    // Bypass is decided per output lane by the mask bit of its source lane.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            for (int l = 0; l < LANES; l++) begin
                if (!w_rin[p]) begin
                    w_rlane[p][l] = '0;
                end else if (w_hit[p] && i_write_mask[w_src[p][l]]) begin
                    w_rlane[p][l] = w_wlane[w_src[p][l]];
                end else begin
                    w_rlane[p][l] = r_mem[C_AW'(w_raddr[p])][w_src[p][l]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rvalid <= '0;
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_rlane[p][l] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                r_rvalid[p] <= o_ready && i_read_en[p];
                if (o_ready && i_read_en[p]) begin
                    for (int l = 0; l < LANES; l++) begin
                        r_rlane[p][l] <= w_rlane[p][l];
                    end
                end
            end
        end
    end

    assign o_read_valid = r_rvalid;

endmodule

`default_nettype wire
